// File: rtl/sm4_pkg.sv
// SM4 shared constants and round-function helpers: S-box, FK/CK key-schedule
// constants, tau/L/L' and the block-mode encoding used by the SM4 engines.
package sm4_pkg;

  localparam int SM4_NUM_ROUNDS = 32;

  typedef enum logic [1:0] {
    SM4_ECB = 2'b00,
    SM4_CBC = 2'b01
  } sm4_mode_t;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  localparam logic [31:0] FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

  localparam logic [31:0] CK [32] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  function automatic logic [31:0] sm4_rotl32(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] sm4_tau(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [31:0] sm4_l(input logic [31:0] b);
    return b ^ sm4_rotl32(b, 5'd2) ^ sm4_rotl32(b, 5'd10) ^ sm4_rotl32(b, 5'd18) ^ sm4_rotl32(b, 5'd24);
  endfunction

  function automatic logic [31:0] sm4_l_key(input logic [31:0] b);
    return b ^ sm4_rotl32(b, 5'd13) ^ sm4_rotl32(b, 5'd23);
  endfunction

endpackage

// File: rtl/sm4_t_func.sv
// SM4 mixer-substitution T (data rounds) or T' (key schedule), selected by
// KEY_MODE; purely combinational.
module sm4_t_func
  import sm4_pkg::*;
#(
  parameter bit KEY_MODE = 1'b0
) (
  input  logic [31:0] x,
  output logic [31:0] y
);

  logic [31:0] tau_s;

  assign tau_s = sm4_tau(x);

  generate
    if (KEY_MODE) begin : g_key
      assign y = sm4_l_key(tau_s);
    end else begin : g_data
      assign y = sm4_l(tau_s);
    end
  endgenerate

endmodule

// File: rtl/sm4_decrypt_engine.sv
// Iterative SM4 ECB/CBC block decryptor: 32-cycle key expansion, 32 rounds with
// reversed round keys. Optional expanded-key reuse via SM4_DEC_KEY_CACHE_EN.
module sm4_decrypt_engine
  import sm4_pkg::*;
#(
  parameter int KEY_WIDTH  = 128,
  parameter int NUM_ROUNDS = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic [KEY_WIDTH-1:0] key,
  input  logic [127:0]         iv,
  input  logic [127:0]         input_data,
  output logic [127:0]         output_data,
  input  logic [1:0]           mode,
  output logic                 error
);

  generate
    if (KEY_WIDTH != 128) begin : g_bad_key_width
      $error("sm4_decrypt_engine: KEY_WIDTH must be 128");
    end
    if (NUM_ROUNDS != SM4_NUM_ROUNDS) begin : g_bad_rounds
      $error("sm4_decrypt_engine: NUM_ROUNDS must be 32");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KEY_EXP = 3'd1,
    S_ROUND   = 3'd2,
    S_FINAL   = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] k_q [4];
  logic [31:0] k_d [4];
  logic [31:0] x_q [4];
  logic [31:0] x_d [4];
  logic [31:0] rk_q [32];
  logic [31:0] rk_d [32];
  logic [127:0] iv_q, iv_d;
  sm4_mode_t   mode_q, mode_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [127:0] out_q, out_d;

  logic [31:0] key_t_in_s, key_t_out_s, rk_new_s;
  logic [31:0] data_t_in_s, data_t_out_s, x_new_s;
  logic [127:0] plain_s;

`ifdef SM4_DEC_KEY_CACHE_EN
  logic [KEY_WIDTH-1:0] cache_key_q, cache_key_d;
  logic                 key_valid_q, key_valid_d;
  logic                 cache_hit_s;

  assign cache_hit_s = key_valid_q && (key == cache_key_q);
`endif

  assign key_t_in_s  = k_q[1] ^ k_q[2] ^ k_q[3] ^ CK[cnt_q];
  // Decryption walks the round-key file backwards: rk31 first.
  assign data_t_in_s = x_q[1] ^ x_q[2] ^ x_q[3] ^ rk_q[5'd31 - cnt_q];

  sm4_t_func #(.KEY_MODE(1'b1)) u_t_key (
    .x(key_t_in_s),
    .y(key_t_out_s)
  );

  sm4_t_func #(.KEY_MODE(1'b0)) u_t_data (
    .x(data_t_in_s),
    .y(data_t_out_s)
  );

  assign rk_new_s = k_q[0] ^ key_t_out_s;
  assign x_new_s  = x_q[0] ^ data_t_out_s;
  assign plain_s  = {x_q[3], x_q[2], x_q[1], x_q[0]};

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    x_d     = x_q;
    rk_d    = rk_q;
    iv_d    = iv_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    out_d   = out_q;
`ifdef SM4_DEC_KEY_CACHE_EN
    cache_key_d = cache_key_q;
    key_valid_d = key_valid_q;
`endif
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          if (mode[1]) begin
            state_d = S_ERROR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            error_d = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = 5'd0;
            iv_d    = iv;
            mode_d  = mode[0] ? SM4_CBC : SM4_ECB;
            x_d[0]  = input_data[127:96];
            x_d[1]  = input_data[95:64];
            x_d[2]  = input_data[63:32];
            x_d[3]  = input_data[31:0];
            k_d[0]  = key[127:96] ^ FK[0];
            k_d[1]  = key[95:64]  ^ FK[1];
            k_d[2]  = key[63:32]  ^ FK[2];
            k_d[3]  = key[31:0]   ^ FK[3];
`ifdef SM4_DEC_KEY_CACHE_EN
            // The round-key file is rewritten from here on, so the cache
            // stays invalid until this expansion completes.
            if (cache_hit_s) begin
              state_d = S_ROUND;
            end else begin
              state_d     = S_KEY_EXP;
              cache_key_d = key;
              key_valid_d = 1'b0;
            end
`else
            state_d = S_KEY_EXP;
`endif
          end
        end else begin
          state_d = state_q;
        end
      end
      S_KEY_EXP: begin
        rk_d[cnt_q] = rk_new_s;
        k_d[0]      = k_q[1];
        k_d[1]      = k_q[2];
        k_d[2]      = k_q[3];
        k_d[3]      = rk_new_s;
        cnt_d       = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_ROUND;
`ifdef SM4_DEC_KEY_CACHE_EN
          key_valid_d = 1'b1;
`endif
        end else begin
          state_d = S_KEY_EXP;
        end
      end
      S_ROUND: begin
        x_d[0] = x_q[1];
        x_d[1] = x_q[2];
        x_d[2] = x_q[3];
        x_d[3] = x_new_s;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FINAL;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_FINAL: begin
        out_d   = (mode_q == SM4_CBC) ? (plain_s ^ iv_q) : plain_s;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        error_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      iv_q    <= 128'h0;
      mode_q  <= SM4_ECB;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      out_q   <= 128'h0;
      for (int i = 0; i < 4; i++) begin
        k_q[i] <= 32'h0;
        x_q[i] <= 32'h0;
      end
      for (int i = 0; i < 32; i++) begin
        rk_q[i] <= 32'h0;
      end
`ifdef SM4_DEC_KEY_CACHE_EN
      cache_key_q <= '0;
      key_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iv_q    <= iv_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      out_q   <= out_d;
      k_q     <= k_d;
      x_q     <= x_d;
      rk_q    <= rk_d;
`ifdef SM4_DEC_KEY_CACHE_EN
      cache_key_q <= cache_key_d;
      key_valid_q <= key_valid_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign output_data = out_q;

endmodule

// File: tb/tb_sm4_decrypt_engine.sv
// Directed self-checking bench for sm4_decrypt_engine (ECB/CBC known answers,
// handshake timing, illegal mode, reset mid-operation, expanded-key reuse).
module tb_sm4_decrypt_engine;

  localparam logic [127:0] KEY_A = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] KEY_B = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_A  = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] PT_A  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] IV_A  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CBC_A = 128'h012247648daecbe8f6d5b0937a593c1f;
`ifdef SM4_DEC_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = 128'h0;
  logic [127:0] iv = 128'h0;
  logic [127:0] input_data = 128'h0;
  logic [1:0]   mode = 2'b00;
  logic         busy, done, error;
  logic [127:0] output_data;

  int           total = 0;
  int           bad = 0;
  logic [127:0] model_key = 128'h0;
  bit           model_valid = 1'b0;

  sm4_decrypt_engine dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .key(key), .iv(iv), .input_data(input_data), .output_data(output_data),
    .mode(mode), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [127:0] k);
    return (CACHE_EN && model_valid && (k == model_key)) ? 34 : 66;
  endfunction

  // Start is sampled at the next rising edge; returns #1 into cycle 1.
  task automatic launch(input logic [127:0] k, input logic [127:0] v,
                        input logic [127:0] d, input logic [1:0] m);
    @(negedge clk);
    key = k; iv = v; input_data = d; mode = m; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    key = ~k; iv = ~v; input_data = ~d; mode = 2'b11;
  endtask

  task automatic run_op(input string tag, input logic [127:0] k, input logic [127:0] v,
                        input logic [127:0] d, input logic [1:0] m,
                        input logic [127:0] exp_out, input bit chk_out);
    int lat;
    int bcnt;
    int elat;
    elat = exp_lat(k);
    launch(k, v, d, m);
    check({tag, "_err_clr"}, {127'h0, error}, 128'h0);
    lat = 1;
    bcnt = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (busy === 1'b1) bcnt++;
    check({tag, "_latency"}, lat, elat);
    check({tag, "_busy_cycles"}, bcnt, elat);
    if (chk_out) check({tag, "_out"}, output_data, exp_out);
    model_key = k;
    model_valid = 1'b1;
  endtask

  // Called in the done cycle: a start here must be ignored; returns in the cycle after done.
  task automatic done_tail(input string tag);
    @(negedge clk);
    key = KEY_A; iv = IV_A; input_data = CT_A; mode = 2'b00; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_tail_busy"}, {127'h0, busy}, 128'h0);
    check({tag, "_tail_done"}, {127'h0, done}, 128'h0);
    check({tag, "_tail_err"}, {127'h0, error}, 128'h0);
  endtask

  initial begin
    bit seen_done;
    int ndone;
    int first_done;
    int elat;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {127'h0, busy}, 128'h0);
    check("rst_done", {127'h0, done}, 128'h0);
    check("rst_error", {127'h0, error}, 128'h0);
    check("rst_out", output_data, 128'h0);
    @(negedge clk);
    rstn = 1'b1;

    run_op("ecb", KEY_A, 128'h0, CT_A, 2'b00, PT_A, 1'b1);
    done_tail("ecb");
    check("ecb_hold", output_data, PT_A);
    run_op("cbc", KEY_A, IV_A, CT_A, 2'b01, CBC_A, 1'b1);
    done_tail("cbc");

    launch(KEY_A, IV_A, CT_A, 2'b10);
    check("ill_error", {127'h0, error}, 128'h1);
    check("ill_busy", {127'h0, busy}, 128'h0);
    check("ill_out", output_data, CBC_A);
    seen_done = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("ill_no_done", {127'h0, seen_done}, 128'h0);
    check("ill_error_held", {127'h0, error}, 128'h1);
    launch(KEY_B, 128'h0, CT_A, 2'b11);
    check("ill_again_error", {127'h0, error}, 128'h1);
    check("ill_again_busy", {127'h0, busy}, 128'h0);
    check("ill_again_out", output_data, CBC_A);
    run_op("recover", KEY_A, 128'h0, CT_A, 2'b00, PT_A, 1'b1);
    @(posedge clk);
    #1;

    launch(KEY_A, IV_A, CT_A, 2'b01);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    check("mid_busy", {127'h0, busy}, 128'h1);
    check("mid_out_held", output_data, PT_A);
    rstn = 1'b0;
    #1;
    check("arst_busy", {127'h0, busy}, 128'h0);
    check("arst_done", {127'h0, done}, 128'h0);
    check("arst_error", {127'h0, error}, 128'h0);
    check("arst_out", output_data, 128'h0);
    model_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    elat = exp_lat(KEY_A);
    launch(KEY_A, 128'h0, CT_A, 2'b00);
    ndone = 0;
    first_done = 0;
    for (int c = 1; c <= 150; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (first_done == 0) first_done = c;
      end
      if (c == 10 || c == 40) begin
        @(negedge clk);
        key = KEY_B; iv = IV_A; input_data = ~CT_A;
        mode = (c == 40) ? 2'b10 : 2'b00;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check("pulse_ndone", ndone, 1);
    check("pulse_latency", first_done, elat);
    check("pulse_out", output_data, PT_A);
    check("pulse_error", {127'h0, error}, 128'h0);
    model_key = KEY_A;
    model_valid = 1'b1;

    run_op("keyb", KEY_B, 128'h0, CT_A, 2'b00, 128'h0, 1'b0);
    done_tail("keyb");
    run_op("keya1", KEY_A, 128'h0, CT_A, 2'b00, PT_A, 1'b1);
    done_tail("keya1");
    run_op("keya2", KEY_A, IV_A, CT_A, 2'b01, CBC_A, 1'b1);
    done_tail("keya2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
